// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared constants and helpers for the ID-stage scoreboard hazard unit.
package hazard_scoreboard_unit_pkg;

  localparam int unsigned REG_ADDRESS_LEN_DEF = 4;
  localparam int unsigned NUM_SRC_DEF         = 3;
  localparam int unsigned LOAD_LATENCY_DEF    = 1;
  localparam int unsigned NOFWD_LATENCY_DEF   = 3;
  localparam int unsigned STALL_CNT_W_DEF     = 16;

  // Which pending-latency class a newly issued writer falls into.
  typedef enum logic [1:0] {
    LAT_NONE,
    LAT_LOAD,
    LAT_NOFWD
  } lat_sel_e;

  // Counter width able to hold the longest pending latency (never zero bits).
  function automatic int unsigned cnt_width(input int unsigned load_lat,
                                            input int unsigned nofwd_lat);
    int unsigned m;
    m = (load_lat > nofwd_lat) ? load_lat : nofwd_lat;
    if (m == 0) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_entry.sv
// One scoreboard counter: counts down pending cycles, reloads with the larger of
// the new latency and the decremented value, holds while the pipeline is frozen.
module hazard_scoreboard_unit_entry #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             busy_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] dec;

  // Next count: saturating decrement, then max-merge with a new pending write.
  always_comb begin
    dec   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    cnt_d = cnt_q;
    if (!freeze_i) begin
      cnt_d = dec;
      if (load_i && (load_val_i > dec)) cnt_d = load_val_i;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: one pending-latency counter per register plus one for
// the CPSR flags; stalls ID while any used source is still in flight.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter int unsigned REG_ADDRESS_LEN = REG_ADDRESS_LEN_DEF,
  parameter int unsigned NUM_SRC         = NUM_SRC_DEF,
  parameter int unsigned LOAD_LATENCY    = LOAD_LATENCY_DEF,
  parameter int unsigned NOFWD_LATENCY   = NOFWD_LATENCY_DEF,
  parameter int unsigned STALL_CNT_W     = STALL_CNT_W_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               id_valid,
  input  logic [NUM_SRC*REG_ADDRESS_LEN-1:0] src_address,
  input  logic [NUM_SRC-1:0]                 src_used,
  input  logic                               reads_flags,
  input  logic [REG_ADDRESS_LEN-1:0]         dest_address,
  input  logic                               wb_en,
  input  logic                               is_load,
  input  logic                               sets_flags,
  input  logic                               forward_en,
  input  logic                               mem_freeze,
  input  logic                               flush,
  output logic                               hazard_detected,
  output logic [(2**REG_ADDRESS_LEN):0]      busy_mask,
  output logic [STALL_CNT_W-1:0]             stall_count
);

  localparam int unsigned NUM_REGS    = 2**REG_ADDRESS_LEN;
  localparam int unsigned FLAGS_INDEX = NUM_REGS;
  localparam int unsigned CNT_W       = cnt_width(LOAD_LATENCY, NOFWD_LATENCY);

  logic [NUM_REGS:0]        busy;
  logic [NUM_REGS:0]        load_en;
  logic                     src_hit;
  logic                     issue;
  lat_sel_e                 wr_sel;
  lat_sel_e                 flag_sel;
  logic [CNT_W-1:0]         wr_lat;
  logic [CNT_W-1:0]         flag_lat;
  logic [STALL_CNT_W-1:0]   stall_q;
  logic [STALL_CNT_W-1:0]   stall_d;

  function automatic logic [CNT_W-1:0] lat_value(input lat_sel_e sel);
    case (sel)
      LAT_LOAD:  return CNT_W'(LOAD_LATENCY);
      LAT_NOFWD: return CNT_W'(NOFWD_LATENCY);
      default:   return '0;
    endcase
  endfunction

  // Source-match OR tree against the pre-update counters, so an instruction
  // that reads its own destination never stalls on itself.
  always_comb begin
    src_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (src_used[i] && busy[{1'b0, src_address[i*REG_ADDRESS_LEN +: REG_ADDRESS_LEN]}])
        src_hit = 1'b1;
    end
    hazard_detected = id_valid & ~flush & (src_hit | (reads_flags & busy[FLAGS_INDEX]));
  end

  assign issue = id_valid & ~flush & ~hazard_detected & ~mem_freeze;

  // Latency of the issuing writer; flags behave like ALU results (no load class).
  always_comb begin
    if (!forward_en)  wr_sel = LAT_NOFWD;
    else if (is_load) wr_sel = LAT_LOAD;
    else              wr_sel = LAT_NONE;
    flag_sel = forward_en ? LAT_NONE : LAT_NOFWD;
    wr_lat   = lat_value(wr_sel);
    flag_lat = lat_value(flag_sel);
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    assign load_en[r] = issue & wb_en & (dest_address == REG_ADDRESS_LEN'(r));

    hazard_scoreboard_unit_entry #(.CNT_W(CNT_W)) u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .freeze_i   (mem_freeze),
      .load_i     (load_en[r]),
      .load_val_i (wr_lat),
      .busy_o     (busy[r])
    );
  end

  assign load_en[FLAGS_INDEX] = issue & sets_flags;

  hazard_scoreboard_unit_entry #(.CNT_W(CNT_W)) u_flags_entry (
    .clk        (clk),
    .rst_n      (rst_n),
    .freeze_i   (mem_freeze),
    .load_i     (load_en[FLAGS_INDEX]),
    .load_val_i (flag_lat),
    .busy_o     (busy[FLAGS_INDEX])
  );

  // Saturating stall counter; frozen cycles are not counted as hazard stalls.
  always_comb begin
    stall_d = stall_q;
    if (hazard_detected && !mem_freeze && (stall_q != '1))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign busy_mask   = busy;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench: a behavioural model pushes expected outputs per cycle, which
// are popped and compared once the DUT has produced them.
module tb_hazard_scoreboard_unit;

  localparam int RAL = 4;
  localparam int NS  = 3;
  localparam int NR  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [NS*RAL-1:0] src_address;
  logic [NS-1:0]     src_used;
  logic              reads_flags;
  logic [RAL-1:0]    dest_address;
  logic              wb_en;
  logic              is_load;
  logic              sets_flags;
  logic              forward_en;
  logic              mem_freeze;
  logic              flush;
  logic              hazard_detected;
  logic [NR:0]       busy_mask;
  logic [15:0]       stall_count;
  logic              hazard_sat;
  logic [NR:0]       busy_sat;
  logic [3:0]        stall_sat;

  always #5 clk = ~clk;

  hazard_scoreboard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .src_address(src_address),
    .src_used(src_used), .reads_flags(reads_flags), .dest_address(dest_address),
    .wb_en(wb_en), .is_load(is_load), .sets_flags(sets_flags), .forward_en(forward_en),
    .mem_freeze(mem_freeze), .flush(flush), .hazard_detected(hazard_detected),
    .busy_mask(busy_mask), .stall_count(stall_count)
  );

  // Narrow stall counter so saturation is reached in a short run.
  hazard_scoreboard_unit #(.STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .src_address(src_address),
    .src_used(src_used), .reads_flags(reads_flags), .dest_address(dest_address),
    .wb_en(wb_en), .is_load(is_load), .sets_flags(sets_flags), .forward_en(forward_en),
    .mem_freeze(mem_freeze), .flush(flush), .hazard_detected(hazard_sat),
    .busy_mask(busy_sat), .stall_count(stall_sat)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  int m_cnt [0:NR];
  int m_stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input string tag);
    case (tag)
      "hazard":     return 32'(hazard_detected);
      "hazard_sat": return 32'(hazard_sat);
      "busy":       return 32'(busy_mask);
      "busy_sat":   return 32'(busy_sat);
      "stall":      return 32'(stall_count);
      "stall_sat":  return 32'(stall_sat);
      default:      return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, observe(e.tag), e.exp);
    end
  endtask

  function automatic void m_reset();
    for (int r = 0; r <= NR; r++) m_cnt[r] = 0;
    m_stall = 0;
  endfunction

  function automatic bit m_hazard();
    bit h = 1'b0;
    for (int i = 0; i < NS; i++) begin
      int idx = int'(src_address[i*RAL +: RAL]);
      if (src_used[i] && m_cnt[idx] != 0) h = 1'b1;
    end
    if (reads_flags && m_cnt[NR] != 0) h = 1'b1;
    return id_valid && !flush && h;
  endfunction

  function automatic logic [NR:0] m_busy();
    logic [NR:0] b = '0;
    for (int r = 0; r <= NR; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  function automatic void m_step(input bit h);
    int nxt [0:NR];
    int lw;
    int lf;
    bit iss;
    if (mem_freeze) return;
    for (int r = 0; r <= NR; r++) nxt[r] = (m_cnt[r] > 0) ? m_cnt[r] - 1 : 0;
    iss = id_valid && !flush && !h;
    lw  = !forward_en ? 3 : (is_load ? 1 : 0);
    lf  = forward_en ? 0 : 3;
    if (iss && wb_en && lw > nxt[int'(dest_address)]) nxt[int'(dest_address)] = lw;
    if (iss && sets_flags && lf > nxt[NR]) nxt[NR] = lf;
    if (h && m_stall < 65535) m_stall++;
    m_cnt = nxt;
  endfunction

  // One clock: called at posedge+1 with inputs already applied.
  task automatic cycle(output bit haz);
    bit mh;
    #1;
    mh = m_hazard();
    push_exp("hazard", 32'(mh));
    push_exp("hazard_sat", 32'(mh));
    drain();
    haz = hazard_detected;
    m_step(mh);
    push_exp("busy", 32'(m_busy()));
    push_exp("busy_sat", 32'(m_busy()));
    push_exp("stall", 32'(m_stall));
    push_exp("stall_sat", 32'((m_stall > 15) ? 15 : m_stall));
    @(posedge clk);
    #1;
    drain();
  endtask

  // Hold one instruction in ID until it issues; returns the stall cycles seen.
  task automatic instr(input logic [NS*RAL-1:0] srcs, input logic [NS-1:0] used,
                       input bit rf, input logic [RAL-1:0] dst, input bit wb,
                       input bit ld, input bit sf, output int stalls);
    bit h;
    id_valid     = 1'b1;
    src_address  = srcs;
    src_used     = used;
    reads_flags  = rf;
    dest_address = dst;
    wb_en        = wb;
    is_load      = ld;
    sets_flags   = sf;
    stalls       = 0;
    h            = 1'b1;
    for (int k = 0; k < 16 && h; k++) begin
      cycle(h);
      if (h) stalls++;
    end
    if (h) check_eq("issue_timeout", 32'(h), 32'd0);
  endtask

  task automatic idle(input int n);
    bit h;
    id_valid   = 1'b0;
    wb_en      = 1'b0;
    sets_flags = 1'b0;
    is_load    = 1'b0;
    for (int k = 0; k < n; k++) cycle(h);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    int base;
    bit h;
    rst_n = 1'b0; id_valid = 1'b0; src_address = '0; src_used = '0; reads_flags = 1'b0;
    dest_address = '0; wb_en = 1'b0; is_load = 1'b0; sets_flags = 1'b0;
    forward_en = 1'b1; mem_freeze = 1'b0; flush = 1'b0;
    m_reset();

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hazard", 32'(hazard_detected), 32'd0);
    check_eq("rst_busy", 32'(busy_mask), 32'd0);
    check_eq("rst_stall", 32'(stall_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // LDR R1 ; ADD R2,R1,R3 with forwarding
    instr({4'd0, 4'd0, 4'd0}, 3'b000, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, st);
    instr({4'd0, 4'd3, 4'd1}, 3'b011, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, st);
    check_eq("ldr_use_stalls", 32'(st), 32'd1);
    check_eq("ldr_use_count", 32'(stall_count), 32'd1);
    idle(4);

    // ADD R1 ; SUB R4,R1,R1 forwarding on then off (Rs slot in second case)
    instr({4'd0, 4'd0, 4'd0}, 3'b000, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, st);
    instr({4'd0, 4'd1, 4'd1}, 3'b011, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, st);
    check_eq("alu_fwd_stalls", 32'(st), 32'd0);
    idle(4);
    forward_en = 1'b0;
    instr({4'd0, 4'd0, 4'd0}, 3'b000, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, st);
    instr({4'd1, 4'd2, 4'd2}, 3'b111, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, st);
    check_eq("alu_nofwd_stalls", 32'(st), 32'd3);
    idle(4);

    // ADDS ; MOVEQ (reads flags) then ADDS ; MOV (AL), forwarding off
    instr({4'd0, 4'd0, 4'd0}, 3'b000, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1, st);
    instr({4'd0, 4'd0, 4'd0}, 3'b000, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, st);
    check_eq("flags_cond_stalls", 32'(st), 32'd3);
    idle(4);
    instr({4'd0, 4'd0, 4'd0}, 3'b000, 1'b0, 4'd6, 1'b1, 1'b0, 1'b1, st);
    instr({4'd0, 4'd0, 4'd0}, 3'b000, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, st);
    check_eq("flags_al_stalls", 32'(st), 32'd0);
    idle(4);

    // LDR R5, then memory freeze for 4 cycles with a dependent in ID
    forward_en = 1'b1;
    instr({4'd0, 4'd0, 4'd0}, 3'b000, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, st);
    base = int'(stall_count);
    mem_freeze = 1'b1;
    id_valid = 1'b1; src_address = {4'd0, 4'd0, 4'd5}; src_used = 3'b001;
    dest_address = 4'd8; is_load = 1'b0; wb_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle(h);
      check_eq("freeze_busy5", 32'(busy_mask[5]), 32'd1);
    end
    mem_freeze = 1'b0;
    instr({4'd0, 4'd0, 4'd5}, 3'b001, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, st);
    check_eq("freeze_release_stalls", 32'(st), 32'd1);
    check_eq("freeze_stall_delta", 32'(int'(stall_count) - base), 32'd1);
    idle(4);

    // Flushed dependent: no hazard, no scoreboard write, counters keep draining
    forward_en = 1'b0;
    instr({4'd0, 4'd0, 4'd0}, 3'b000, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, st);
    flush = 1'b1;
    id_valid = 1'b1; src_address = {4'd0, 4'd0, 4'd8}; src_used = 3'b001;
    dest_address = 4'd9; wb_en = 1'b1; sets_flags = 1'b1;
    cycle(h);
    check_eq("flush_hazard", 32'(h), 32'd0);
    check_eq("flush_no_write9", 32'(busy_mask[9]), 32'd0);
    check_eq("flush_no_flags", 32'(busy_mask[NR]), 32'd0);
    check_eq("flush_r8_pending", 32'(busy_mask[8]), 32'd1);
    flush = 1'b0;
    idle(4);

    // Repeated self-dependent writer: drives the narrow stall counter to saturation
    for (int k = 0; k < 8; k++)
      instr({4'd0, 4'd0, 4'd10}, 3'b001, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0, st);
    check_eq("sat_hold", 32'(stall_sat), 32'd15);
    idle(4);

    // forward_en change affects only new writers
    instr({4'd0, 4'd0, 4'd0}, 3'b000, 1'b0, 4'd12, 1'b1, 1'b0, 1'b0, st);
    forward_en = 1'b1;
    instr({4'd0, 4'd12, 4'd0}, 3'b010, 1'b0, 4'd13, 1'b1, 1'b0, 1'b0, st);
    check_eq("fwd_toggle_stalls", 32'(st), 32'd3);
    idle(2);

    // Mid-stream async reset with an entry busy and a dependent in ID
    forward_en = 1'b0;
    instr({4'd0, 4'd0, 4'd0}, 3'b000, 1'b0, 4'd11, 1'b1, 1'b0, 1'b1, st);
    id_valid = 1'b1; src_address = {4'd0, 4'd0, 4'd11}; src_used = 3'b001;
    reads_flags = 1'b1; dest_address = 4'd3; wb_en = 1'b1; sets_flags = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    push_exp("hazard", 32'd0);
    push_exp("busy", 32'd0);
    push_exp("stall", 32'd0);
    push_exp("stall_sat", 32'd0);
    drain();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    cycle(h);
    check_eq("post_reset_hazard", 32'(h), 32'd0);
    reads_flags = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
